// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer for the rv32 core.
// Steps each instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK,
// drives the datapath enables, handshakes with instruction/data memory and
// parks the core in HALT on a debug request or on a hung memory bus.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt_req,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 reg_write,
  input  logic                 load,
  input  logic                 store,
  input  logic                 branch,
  input  logic                 branch_taken,
  input  logic                 next_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 rf_write_en,
  output logic [2:0]           state,
  output logic                 bus_error,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  // Wait counter only has to reach MEM_TIMEOUT-1; with the timeout disabled
  // it is free-running and its wrap is harmless.
  localparam int             WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit             TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [2:0]           state_q, state_d;
  logic [WCW-1:0]       wait_cnt;
  logic                 wait_inc;
  logic                 bus_err_q, set_berr;
  logic [INSTRET_W-1:0] instret_q;

  // Raw (pre-reset-gating) output decodes.
  logic ireq_r, dreq_r, dwe_r, irw_r, pcw_r, rfw_r, hlt_r;
  logic wait_limit;

  assign wait_limit = TO_EN && (wait_cnt == WAIT_LAST);

  // Next-state and output decode from the registered state and live inputs.
  always_comb begin
    state_d  = state_q;
    wait_inc = 1'b0;
    set_berr = 1'b0;
    ireq_r   = 1'b0;
    dreq_r   = 1'b0;
    dwe_r    = 1'b0;
    irw_r    = 1'b0;
    pcw_r    = 1'b0;
    rfw_r    = 1'b0;
    hlt_r    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ireq_r = 1'b1;
        if (imem_ready) begin
          // A completing fetch wins over both halt and the timeout limit.
          irw_r   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_limit) begin
          state_d  = S_HALT;
          set_berr = 1'b1;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (load || store) begin
          state_d = S_MEMORY;
        end else if (reg_write) begin
          state_d = S_WRITEBACK;
        end else begin
          // Branches retire straight from EXECUTE.
          pcw_r   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMORY: begin
        // halt_req is deliberately ignored: a started data access completes.
        dreq_r = 1'b1;
        dwe_r  = store & ~load;
        if (dmem_ready) begin
          if (load) begin
            state_d = S_WRITEBACK;
          end else begin
            pcw_r   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_limit) begin
          state_d  = S_HALT;
          set_berr = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rfw_r   = reg_write;
        pcw_r   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        hlt_r = 1'b1;
        // A bus error is terminal until reset.
        if (!halt_req && !bus_err_q) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Consecutive-wait counter; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst)                     wait_cnt <= '0;
    else if (state_d != state_q) wait_cnt <= '0;
    else if (wait_inc)           wait_cnt <= wait_cnt + WCW'(1);
  end

  // Sticky bus error flag.
  always_ff @(posedge clk) begin
    if (rst)           bus_err_q <= 1'b0;
    else if (set_berr) bus_err_q <= 1'b1;
  end

  // Retired-instruction counter, one per retire strobe, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)        instret_q <= '0;
    else if (pcw_r) instret_q <= instret_q + INSTRET_W'(1);
  end

  // Every output is held low while reset is asserted.
  always_comb begin
    imem_req    = ~rst & ireq_r;
    dmem_req    = ~rst & dreq_r;
    dmem_we     = ~rst & dwe_r;
    ir_write    = ~rst & irw_r;
    pc_write    = ~rst & pcw_r;
    pc_src      = ~rst & (next_sel | (branch & branch_taken));
    rf_write_en = ~rst & rfw_r;
    halted      = ~rst & hlt_r;
    bus_error   = ~rst & bus_err_q;
    state       = rst ? 3'd0 : state_q;
    instret     = rst ? '0 : instret_q;
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. The stimulus process drives one
// cycle at a time and queues the hand-computed output set for that cycle; a
// monitor on the falling edge pops and compares.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, halt_req, imem_ready, dmem_ready;
  logic        reg_write, load, store, branch, branch_taken, next_sel;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, rf_write_en;
  logic        bus_error, halted;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_write(reg_write), .load(load), .store(store), .branch(branch),
    .branch_taken(branch_taken), .next_sel(next_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .rf_write_en(rf_write_en), .state(state), .bus_error(bus_error),
    .halted(halted), .instret(instret)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ireq, irw, dreq, dwe, pcw, pcs, rfw, berr, hlt;
    logic [31:0] ic;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic exp_t X(input logic [2:0] st, input logic ireq, irw, dreq, dwe,
                             pcw, pcs, rfw, berr, hlt, input int ic);
    exp_t e;
    e.st = st; e.ireq = ireq; e.irw = irw; e.dreq = dreq; e.dwe = dwe;
    e.pcw = pcw; e.pcs = pcs; e.rfw = rfw; e.berr = berr; e.hlt = hlt;
    e.ic = ic;
    return e;
  endfunction

  // Monitor: pc_src is only meaningful on a retire strobe, so it is masked otherwise.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, g;
      e = exp_q.pop_front();
      g.st = state; g.ireq = imem_req; g.irw = ir_write; g.dreq = dmem_req;
      g.dwe = dmem_we; g.pcw = pc_write; g.pcs = e.pcw ? pc_src : 1'b0;
      g.rfw = rf_write_en; g.berr = bus_error; g.hlt = halted; g.ic = instret;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle%0d outputs: got st=%0d ireq=%b irw=%b dreq=%b dwe=%b pcw=%b pcs=%b rfw=%b berr=%b hlt=%b ic=%0d ; exp st=%0d ireq=%b irw=%b dreq=%b dwe=%b pcw=%b pcs=%b rfw=%b berr=%b hlt=%b ic=%0d",
                 cyc, g.st, g.ireq, g.irw, g.dreq, g.dwe, g.pcw, g.pcs, g.rfw, g.berr, g.hlt, g.ic,
                 e.st, e.ireq, e.irw, e.dreq, e.dwe, e.pcw, e.pcs, e.rfw, e.berr, e.hlt, e.ic);
      end
      cyc++;
    end
  end

  task automatic cls(input logic rw, ld, st, br, bt, ns);
    reg_write = rw; load = ld; store = st; branch = br; branch_taken = bt; next_sel = ns;
  endtask

  task automatic cy(input logic r, hr, ir, dr, input exp_t e);
    rst = r; halt_req = hr; imem_ready = ir; dmem_ready = dr;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    cls(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset: everything low.
    cy(1, 0, 0, 0, X(0, 0,0,0,0,0,0,0,0,0, 0));
    cy(1, 0, 0, 0, X(0, 0,0,0,0,0,0,0,0,0, 0));

    // ALU op, zero-wait: 4 cycles.
    cls(1, 0, 0, 0, 0, 0);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(4, 0,0,0,0,1,0,1,0,0, 0));

    // Taken branch: retires from EXECUTE, 3 cycles, pc_src=1.
    cls(0, 0, 0, 1, 1, 0);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 1));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 1));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,1,1,0,0,0, 1));

    // Load, dmem_ready on the 4th request cycle (which is also the timeout limit).
    cls(1, 1, 0, 0, 0, 0);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(3, 0,0,1,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(3, 0,0,1,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(3, 0,0,1,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 1, X(3, 0,0,1,0,0,0,0,0,0, 2));
    cy(0, 0, 0, 0, X(4, 0,0,0,0,1,0,1,0,0, 2));

    // Store, same delay: retires on the ready cycle, no rf write.
    cls(0, 0, 1, 0, 0, 0);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 3));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 3));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 3));
    cy(0, 0, 0, 0, X(3, 0,0,1,1,0,0,0,0,0, 3));
    cy(0, 0, 0, 0, X(3, 0,0,1,1,0,0,0,0,0, 3));
    cy(0, 0, 0, 0, X(3, 0,0,1,1,0,0,0,0,0, 3));
    cy(0, 0, 0, 1, X(3, 0,0,1,1,1,0,0,0,0, 3));

    // jal: writeback with pc_src=1.
    cls(1, 0, 0, 0, 0, 1);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 4));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 4));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 4));
    cy(0, 0, 0, 0, X(4, 0,0,0,0,1,1,1,0,0, 4));

    // Debug halt while fetch is stalled, then release.
    cy(0, 1, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 5));
    cy(0, 1, 0, 0, X(5, 0,0,0,0,0,0,0,0,1, 5));
    cy(0, 0, 0, 0, X(5, 0,0,0,0,0,0,0,0,1, 5));

    // Fetch completes despite halt_req; halt_req ignored through MEMORY.
    cls(1, 1, 0, 0, 0, 0);
    cy(0, 1, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 5));
    cy(0, 1, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 5));
    cy(0, 1, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 5));
    cy(0, 1, 0, 0, X(3, 0,0,1,0,0,0,0,0,0, 5));
    cy(0, 1, 0, 1, X(3, 0,0,1,0,0,0,0,0,0, 5));
    cy(0, 0, 0, 0, X(4, 0,0,0,0,1,0,1,0,0, 5));

    // Fetch timeout: exactly 4 request cycles, then sticky HALT.
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 6));
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 6));
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 6));
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 6));
    cy(0, 0, 0, 0, X(5, 0,0,0,0,0,0,0,1,1, 6));
    cy(0, 0, 1, 0, X(5, 0,0,0,0,0,0,0,1,1, 6));
    cy(0, 0, 0, 0, X(5, 0,0,0,0,0,0,0,1,1, 6));
    cy(1, 0, 0, 0, X(0, 0,0,0,0,0,0,0,0,0, 0));

    // Fresh load, reset while in MEMORY: nothing retires.
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(3, 0,0,1,0,0,0,0,0,0, 0));
    cy(1, 0, 0, 1, X(0, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 0));

    // Normal ALU op after reset; counter restarts from 0.
    cls(1, 0, 0, 0, 0, 0);
    cy(0, 0, 1, 0, X(0, 1,1,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(1, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(2, 0,0,0,0,0,0,0,0,0, 0));
    cy(0, 0, 0, 0, X(4, 0,0,0,0,1,0,1,0,0, 0));
    cy(0, 0, 0, 0, X(0, 1,0,0,0,0,0,0,0,0, 1));

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
